// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared APB bridge definitions. Holds the transfer state
//                encoding and the strobe-width helper used by both the APB
//                requester (master adapter) and the APB completer (slave
//                adapter), so the two ends agree on pstrb width.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Transfer phase of the requester. IDLE waits for a local request,
    // SETUP/ACCESS are the two APB phases, RESP holds the local response.
    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2,
        APB_RESP   = 2'd3
    } apb_state_e;

    // Number of pstrb bits for a given data width. Buses narrower than a
    // byte still carry a single strobe; wider buses round up to a power of
    // two bytes.
    function automatic int apb_byte_count(input int data_width);
        if (data_width < 8) begin
            return 1;
        end
        return 2 ** ($clog2(data_width) - 3);
    endfunction

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_master_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_adapter
//  Description : Local valid/ready request/response port to APB requester.
//                Takes one register read or write, runs the APB SETUP and
//                ACCESS phases, waits for pready (with an optional timeout)
//                and returns read data / error on the response port.
//                Only one transfer is outstanding at a time.
//  Ports       :
//    pclk, preset          clock, asynchronous active-high reset
//    req_valid/req_ready   request handshake (ready only while idle)
//    req_addr/req_write    request address and direction
//    req_wstrb/req_wdata   write strobes and write data
//    rsp_valid/rsp_ready   response handshake
//    rsp_rdata/rsp_err     read data (0 for writes/timeouts), error flag
//    paddr..pwdata         APB requester outputs (all registered)
//    prdata/pready/pslverr APB completer inputs, sampled only in ACCESS
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_adapter
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_EN        = 0,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int BYTE_COUNT     = apb_byte_count(DATA_WIDTH)
) (
    input  logic                  pclk,
    input  logic                  preset,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [BYTE_COUNT-1:0] req_wstrb,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [BYTE_COUNT-1:0] pstrb,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    // Counter must reach TIMEOUT_CYCLES-1; keep at least one bit when the
    // timeout is disabled so the register stays legal.
    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] c_TIMEOUT_LAST =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

    apb_state_e    r_state;
    logic [CW-1:0] r_count;
    logic          w_timeout;

    // Expires on the TIMEOUT_CYCLES-th ACCESS cycle without pready.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_count == c_TIMEOUT_LAST);

    // The only combinational output: a request can be taken only when idle.
    assign req_ready = (r_state == APB_IDLE);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= APB_IDLE;
            r_count   <= '0;
            paddr     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pstrb     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                APB_IDLE: begin
                    if (req_valid) begin
                        paddr   <= req_addr;
                        pwrite  <= req_write;
                        pwdata  <= req_wdata;
                        // Reads never drive strobes; writes either pass the
                        // request strobes through or enable every byte.
                        pstrb   <= req_write ?
                                   ((BYTE_EN != 0) ? req_wstrb : {BYTE_COUNT{1'b1}}) :
                                   '0;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        r_state <= APB_SETUP;
                    end
                end

                APB_SETUP: begin
                    penable <= 1'b1;
                    r_count <= '0;
                    r_state <= APB_ACCESS;
                end

                APB_ACCESS: begin
                    // pready is checked first so a completion on the same
                    // cycle as the timeout is treated as a normal transfer.
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        r_state   <= APB_RESP;
                    end else if (w_timeout) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        r_state   <= APB_RESP;
                    end else if (r_count != {CW{1'b1}}) begin
                        r_count <= r_count + 1'b1;
                    end
                end

                APB_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        r_state   <= APB_IDLE;
                    end
                end

                default: begin
                    r_state <= APB_IDLE;
                end
            endcase
        end
    end

endmodule : apb_master_adapter
`default_nettype wire

// File: tb/tb_apb_master_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_adapter
//  Description : Self-checking bench for apb_master_adapter. A second
//                instance with BYTE_EN=1 shares all inputs so strobe
//                pass-through can be compared against the default build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_adapter;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        pclk;
    logic        preset;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic        req_write;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    // Outputs of the BYTE_EN=1 instance
    logic        be_req_ready;
    logic        be_rsp_valid;
    logic [31:0] be_rsp_rdata;
    logic        be_rsp_err;
    logic [11:0] be_paddr;
    logic        be_psel;
    logic        be_penable;
    logic        be_pwrite;
    logic [3:0]  be_pstrb;
    logic [31:0] be_pwdata;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[$];

    // Completer model
    int          slv_waits = 0;
    logic        slv_hang  = 1'b0;
    logic        slv_err   = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    int          acc_cnt   = 0;

    assign pready  = psel && penable && !slv_hang && (acc_cnt >= slv_waits);
    assign prdata  = pready ? slv_rdata : 32'hBAD0_BAD0;
    assign pslverr = pready && slv_err;

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    apb_master_adapter #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .BYTE_EN(0), .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    apb_master_adapter #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .BYTE_EN(1), .TIMEOUT_CYCLES(16)
    ) dut_be (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(be_req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(be_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(be_rsp_rdata),
        .rsp_err(be_rsp_err),
        .paddr(be_paddr), .psel(be_psel), .penable(be_penable), .pwrite(be_pwrite),
        .pstrb(be_pstrb), .pwdata(be_pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Present a request and hold it until the accepting edge has passed.
    // Returns just after that edge (first SETUP cycle).
    task automatic send_req(input logic [11:0] a, input logic w,
                            input logic [31:0] d, input logic [3:0] s);
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        req_wstrb = s;
        req_valid = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        if (!req_ready) begin
            compared++; mismatched++;
            $display("FAIL req_accept: req_ready=%b required 1 within 50 cycles", req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 64) begin
            tick();
            cyc++;
        end
        if (!rsp_valid) begin
            compared++; mismatched++;
            $display("FAIL rsp_wait: rsp_valid=%b required 1 within 64 cycles", rsp_valid);
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        tick(); tick();
        compared++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: psel/penable/pwrite/rsp_valid/rsp_err=%b required 00000",
                     {psel, penable, pwrite, rsp_valid, rsp_err});
        end
        compared++;
        if ({paddr, pstrb, pwdata, rsp_rdata} !== '0) begin
            mismatched++;
            $display("FAIL reset_data: paddr=%h pstrb=%h pwdata=%h rsp_rdata=%h required all 0",
                     paddr, pstrb, pwdata, rsp_rdata);
        end
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_req_ready: got %b required 1", req_ready);
        end
        @(negedge pclk);
        preset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        exp_t e;
        slv_waits = 0; slv_err = 1'b0; rsp_ready = 1'b1;
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        send_req(12'h010, 1'b1, 32'hDEAD_BEEF, 4'h0);
        // SETUP
        compared++;
        if ({psel, penable} !== 2'b10) begin
            mismatched++;
            $display("FAIL wr_setup: psel/penable=%b required 10", {psel, penable});
        end
        compared++;
        if (paddr !== 12'h010 || pwrite !== 1'b1 || pwdata !== 32'hDEAD_BEEF || pstrb !== 4'hF) begin
            mismatched++;
            $display("FAIL wr_bus: paddr=%h pwrite=%b pwdata=%h pstrb=%h required 010 1 deadbeef f",
                     paddr, pwrite, pwdata, pstrb);
        end
        tick();
        // ACCESS
        compared++;
        if ({psel, penable, rsp_valid} !== 3'b110) begin
            mismatched++;
            $display("FAIL wr_access: psel/penable/rsp_valid=%b required 110", {psel, penable, rsp_valid});
        end
        tick();
        // Response, three cycles after the accepting edge
        compared++;
        if ({rsp_valid, psel, penable} !== 3'b100) begin
            mismatched++;
            $display("FAIL wr_rsp_timing: rsp_valid/psel/penable=%b required 100", {rsp_valid, psel, penable});
        end
        if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL wr_sb: scoreboard empty, required 1 entry");
        end else begin
            e = sb.pop_front();
            compared++;
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                mismatched++;
                $display("FAIL wr_rsp: rdata=%h err=%b required %h %b", rsp_rdata, rsp_err, e.rdata, e.err);
            end
        end
        tick();
        compared++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL wr_done: rsp_valid/req_ready=%b required 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_read_wait();
        exp_t e;
        int   en_cycles;
        int   guard;
        slv_waits = 3; slv_rdata = 32'h1234_5678; slv_err = 1'b0; rsp_ready = 1'b1;
        sb.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        send_req(12'h020, 1'b0, 32'hFFFF_FFFF, 4'hF);
        compared++;
        if (pstrb !== 4'h0 || pwrite !== 1'b0 || paddr !== 12'h020) begin
            mismatched++;
            $display("FAIL rd_setup: pstrb=%h pwrite=%b paddr=%h required 0 0 020", pstrb, pwrite, paddr);
        end
        en_cycles = 0;
        guard = 0;
        while (!rsp_valid && guard < 40) begin
            tick();
            guard++;
            if (penable) en_cycles++;
        end
        compared++;
        if (en_cycles !== 4) begin
            mismatched++;
            $display("FAIL rd_penable_len: penable cycles=%0d required 4", en_cycles);
        end
        if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL rd_sb: scoreboard empty, required 1 entry");
        end else begin
            e = sb.pop_front();
            compared++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                mismatched++;
                $display("FAIL rd_rsp: valid=%b rdata=%h err=%b required 1 %h %b",
                         rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
            end
        end
        tick();
        slv_waits = 0;
    endtask

    task automatic test_byte_en();
        exp_t e;
        int   cyc;
        rsp_ready = 1'b1;
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        send_req(12'h030, 1'b1, 32'hA5A5_A5A5, 4'b0101);
        compared++;
        if (be_pstrb !== 4'b0101) begin
            mismatched++;
            $display("FAIL be_pstrb: got %b required 0101", be_pstrb);
        end
        compared++;
        if (pstrb !== 4'hF) begin
            mismatched++;
            $display("FAIL nobe_pstrb: got %b required 1111", pstrb);
        end
        wait_rsp(cyc);
        if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL be_sb: scoreboard empty, required 1 entry");
        end else begin
            e = sb.pop_front();
            compared++;
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                mismatched++;
                $display("FAIL be_rsp: rdata=%h err=%b required %h %b", rsp_rdata, rsp_err, e.rdata, e.err);
            end
        end
        tick();
    endtask

    task automatic test_slverr();
        exp_t e;
        int   cyc;
        slv_waits = 1; slv_err = 1'b1; slv_rdata = 32'hCAFE_F00D; rsp_ready = 1'b1;
        sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b1});
        send_req(12'h044, 1'b0, 32'h0, 4'h0);
        wait_rsp(cyc);
        if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL err_sb: scoreboard empty, required 1 entry");
        end else begin
            e = sb.pop_front();
            compared++;
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                mismatched++;
                $display("FAIL err_rsp: rdata=%h err=%b required %h %b", rsp_rdata, rsp_err, e.rdata, e.err);
            end
        end
        tick();
        compared++;
        if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL err_clear: rsp_err=%b rsp_valid=%b required 0 0", rsp_err, rsp_valid);
        end
        slv_err = 1'b0; slv_waits = 0;
    endtask

    task automatic test_timeout();
        exp_t e;
        int   acc_cycles;
        int   guard;
        slv_hang = 1'b1; slv_rdata = 32'h7777_7777; rsp_ready = 1'b1;
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        send_req(12'h0F0, 1'b0, 32'h0, 4'h0);
        acc_cycles = 0;
        guard = 0;
        while (!rsp_valid && guard < 64) begin
            tick();
            guard++;
            if (psel && penable) acc_cycles++;
        end
        compared++;
        if (acc_cycles !== 16) begin
            mismatched++;
            $display("FAIL to_len: ACCESS cycles=%0d required 16", acc_cycles);
        end
        compared++;
        if ({rsp_valid, psel, penable} !== 3'b100) begin
            mismatched++;
            $display("FAIL to_release: rsp_valid/psel/penable=%b required 100", {rsp_valid, psel, penable});
        end
        if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL to_sb: scoreboard empty, required 1 entry");
        end else begin
            e = sb.pop_front();
            compared++;
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                mismatched++;
                $display("FAIL to_rsp: rdata=%h err=%b required %h %b", rsp_rdata, rsp_err, e.rdata, e.err);
            end
        end
        tick();
        slv_hang = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        slv_waits = 0; slv_rdata = 32'h0BAD_CAFE; rsp_ready = 1'b0;
        sb.push_back('{rdata: 32'h0BAD_CAFE, err: 1'b0});
        send_req(12'h050, 1'b0, 32'h0, 4'h0);
        wait_rsp(cyc);
        e = (sb.size() != 0) ? sb[0] : '{rdata: 32'hFFFF_FFFF, err: 1'b1};
        // A second request waits while the first response is held
        req_addr = 12'h060; req_write = 1'b1; req_wdata = 32'h1122_3344; req_wstrb = 4'hF;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            compared++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                mismatched++;
                $display("FAIL bp_hold[%0d]: valid=%b rdata=%h err=%b required 1 %h %b",
                         i, rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
            end
            compared++;
            if (req_ready !== 1'b0 || psel !== 1'b0 || paddr !== 12'h050) begin
                mismatched++;
                $display("FAIL bp_block[%0d]: req_ready=%b psel=%b paddr=%h required 0 0 050",
                         i, req_ready, psel, paddr);
            end
        end
        if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL bp_sb: scoreboard empty, required 1 entry");
        end else begin
            e = sb.pop_front();
            compared++;
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                mismatched++;
                $display("FAIL bp_rsp: rdata=%h err=%b required %h %b", rsp_rdata, rsp_err, e.rdata, e.err);
            end
        end
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        rsp_ready = 1'b1;
        tick();
        compared++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            mismatched++;
            $display("FAIL bp_consume: rsp_valid/req_ready=%b required 01", {rsp_valid, req_ready});
        end
        tick();
        req_valid = 1'b0;
        compared++;
        if (psel !== 1'b1 || paddr !== 12'h060 || pwrite !== 1'b1 || pwdata !== 32'h1122_3344) begin
            mismatched++;
            $display("FAIL b2b_setup: psel=%b paddr=%h pwrite=%b pwdata=%h required 1 060 1 11223344",
                     psel, paddr, pwrite, pwdata);
        end
        wait_rsp(cyc);
        if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL b2b_sb: scoreboard empty, required 1 entry");
        end else begin
            e = sb.pop_front();
            compared++;
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                mismatched++;
                $display("FAIL b2b_rsp: rdata=%h err=%b required %h %b", rsp_rdata, rsp_err, e.rdata, e.err);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        slv_hang = 1'b1; rsp_ready = 1'b1;
        sb.push_back('{rdata: 32'h0, err: 1'b1});
        send_req(12'h070, 1'b0, 32'h0, 4'h0);
        tick();
        compared++;
        if ({psel, penable} !== 2'b11) begin
            mismatched++;
            $display("FAIL rst_pre: psel/penable=%b required 11", {psel, penable});
        end
        #2;
        preset = 1'b1;
        #1;
        compared++;
        if ({psel, penable, rsp_valid} !== 3'b000) begin
            mismatched++;
            $display("FAIL rst_async: psel/penable/rsp_valid=%b required 000", {psel, penable, rsp_valid});
        end
        // The aborted transfer never produces a response
        sb.delete();
        @(negedge pclk);
        preset = 1'b0;
        slv_hang = 1'b0;
        tick();
        compared++;
        if ({req_ready, psel, rsp_valid} !== 3'b100) begin
            mismatched++;
            $display("FAIL rst_release: req_ready/psel/rsp_valid=%b required 100", {req_ready, psel, rsp_valid});
        end
    endtask

    initial begin
        preset    = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wstrb = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        test_reset();
        test_write();
        test_read_wait();
        test_byte_en();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_apb_master_adapter
`default_nettype wire
